// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the main control FSM and the multiply/divide sequencer.
interface muldiv_ctrl_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        HI_writeControl;
  logic        LO_writeControl;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, HI_writeControl, LO_writeControl, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, HI_writeControl, LO_writeControl, hi, lo
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative 32-step signed Booth multiply / restoring divide sequencer feeding HI/LO.
// All outputs are registered from next-state decode; reset is synchronous active-high.
module muldiv_ctrl (
  input  logic          clock,
  input  logic          reset,
  muldiv_ctrl_if.slave  bus
);
  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned AW = 2 * W + 3;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  dvsr_q, dvsr_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          sa_q, sa_d, sb_q, sb_d;
  logic          is_div_q, is_div_d;
  logic          dz_q, dz_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dzo_q, dzo_d;
  logic          we_q, we_d;
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;

  logic [W+1:0]  mcand_ext, sum;
  logic [W:0]    rshift, trial;

  // Next-state, datapath step and registered-output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    rem_d    = rem_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_ext = {{2{mcand_q[W-1]}}, mcand_q};
    sum       = acc_q[AW-1:W+1];
    rshift    = {rem_q, quot_q[W-1]};
    trial     = rshift - {1'b0, dvsr_q};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d = CW'(W - 1);
          if (!bus.op) begin
            acc_d    = {(W+2)'(0), bus.b, 1'b0};
            mcand_d  = bus.a;
            is_div_d = 1'b0;
            dz_d     = 1'b0;
            state_d  = S_MUL;
          end else if (bus.b == '0) begin
            cnt_d    = cnt_q;
            is_div_d = 1'b1;
            dz_d     = 1'b1;
            state_d  = S_DONE;
          end else begin
            sa_d     = bus.a[W-1];
            sb_d     = bus.b[W-1];
            quot_d   = bus.a[W-1] ? W'(-bus.a) : bus.a;
            dvsr_d   = bus.b[W-1] ? W'(-bus.b) : bus.b;
            rem_d    = '0;
            is_div_d = 1'b1;
            dz_d     = 1'b0;
            state_d  = S_DIV;
          end
        end
      end
      S_MUL: begin
        // Booth pair {q0, q-1}: 01 adds, 10 subtracts, then arithmetic shift right
        case (acc_q[1:0])
          2'b01:   sum = acc_q[AW-1:W+1] + mcand_ext;
          2'b10:   sum = acc_q[AW-1:W+1] - mcand_ext;
          default: sum = acc_q[AW-1:W+1];
        endcase
        acc_d = {sum[W+1], sum, acc_q[W:1]};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_DIV: begin
        if (trial[W]) begin
          rem_d  = rshift[W-1:0];
          quot_d = {quot_q[W-2:0], 1'b0};
        end else begin
          rem_d  = trial[W-1:0];
          quot_d = {quot_q[W-2:0], 1'b1};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = (sa_q ^ sb_q) ? W'(-quot_q) : quot_q;
          hi_d = sa_q ? W'(-rem_q) : rem_q;
        end else begin
          hi_d = acc_q[2*W:W+1];
          lo_d = acc_q[W:1];
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    dzo_d  = done_d & dz_d;
    we_d   = done_d & ~dz_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      rem_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dzo_q    <= 1'b0;
      we_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      rem_q    <= rem_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dzo_q    <= dzo_d;
      we_q     <= we_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.div_zero        = dzo_q;
  assign bus.HI_writeControl = we_q;
  assign bus.LO_writeControl = we_q;
  assign bus.hi              = hi_q;
  assign bus.lo              = lo_q;
endmodule
